adc_spi_rx_multi: RTL and testbench
===================================

# adc_spi_rx_multi

Parametrised multi-lane SPI ADC receiver: generates `sclk`/`cs` for one or more serial ADCs sharing clock and chip-select, deserialises each `sdata` lane in parallel, and presents framed words plus extracted conversion data with a one-cycle done strobe. Supports single-shot and continuous conversion, and flags frames whose leading pad bits are non-zero. It sits between the off-chip ADCs (AD7476-class, 4 zeros + 12 data bits) and the sample-processing logic.

## Interface
Parameters:
- `CHANNELS`, 2, number of `sdata` lanes (≥1)
- `FRAME_BITS`, 16, SCLK periods per frame (≥2)
- `DATA_BITS`, 12, conversion bits at frame LSB end (1..FRAME_BITS)
- `CLK_DIV`, 4, `clk` cycles per SCLK half-period (≥1)
- `QUIET_CYCLES`, 8, minimum `clk` cycles with `cs` high between frames (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1, system clock
- `reset` in 1, async active-low reset
- `start` in 1, single-shot request, sampled only in IDLE
- `cont` in 1, continuous mode: restart automatically while high
- `sdata` in CHANNELS, serial data, lane i from ADC i
- `sclk` out 1, serial clock, idles low
- `cs` out 1, chip select, active low
- `busy` out 1, high from `cs` fall until return to IDLE
- `rx_done_tick` out 1, one-cycle pulse, frame complete
- `frame_reg` out CHANNELS*FRAME_BITS, raw frames, lane i at [i*FRAME_BITS +: FRAME_BITS]
- `data_out` out CHANNELS*DATA_BITS, lane i = frame[DATA_BITS-1:0]
- `frame_err` out CHANNELS, lane i high if any of top FRAME_BITS-DATA_BITS frame bits is 1

## Operation
- States: IDLE → SETUP → SHIFT → QUIET → IDLE.
- IDLE: `cs`=1, `sclk`=0, `busy`=0. If `start|cont` → SETUP, `cs`=0 next cycle.
- SETUP: `sclk` low for CLK_DIV cycles; then `sclk` rises, enter SHIFT.
- SHIFT: `sclk` alternates high/low every CLK_DIV cycles, FRAME_BITS rising edges. On the cycle `sclk` is registered 0→1, all lanes shift in `sdata[i]` MSB-first. After the last rising edge's high half plus one low half → `cs`=1, outputs update, `rx_done_tick`=1, enter QUIET.
- Slave contract: MSB valid at `cs` fall, next bit after each `sclk` falling edge.
- QUIET: `cs`=1 for QUIET_CYCLES cycles, then IDLE.
- `frame_reg`, `data_out`, `frame_err` update only at frame completion, all lanes atomically; they hold otherwise.
- `start` outside IDLE ignored (not queued). `cont` dropped mid-frame: current frame completes, no restart.
- Reset mid-frame: immediately `cs`=1, `sclk`=0, partial shift discarded, outputs cleared.

## Timing
- Reset values: `sclk`=0, `cs`=1, `busy`=0, `rx_done_tick`=0, `frame_reg`/`data_out`/`frame_err`=0.
- `start` sampled at edge 0 → `cs` low from cycle 1 through cycle T−1, T = 1 + CLK_DIV*(2*FRAME_BITS+1); `cs` high and `rx_done_tick` high in cycle T (defaults: T=133).
- Outputs valid in same cycle as `rx_done_tick`.
- Continuous period (`cs` fall to `cs` fall) = T + QUIET_CYCLES (defaults: 141).
- Bit counter width $clog2(FRAME_BITS+1); divider width $clog2(CLK_DIV+1).

## Structure
- Package `adc_rx_pkg`: state enum, frame-field extraction function (data slice, pad-zero check).
- Sub-module `adc_lane_shift` (FRAME_BITS shift register, shift enable, capture), instantiated CHANNELS times via generate; top holds FSM, divider, bit counter.

## Test plan
- Single shot, defaults: lane0 16'h0ABC, lane1 16'h0123 → at cycle 133 `data_out`={12'h123,12'hABC}, `frame_err`=2'b00, `rx_done_tick` one cycle, exactly 16 `sclk` rises.
- Pad error: lane0 16'h8ABC → `frame_err[0]`=1, `data_out` lane0 = 12'hABC, `frame_reg` lane0 = 16'h8ABC.
- Continuous: `cont`=1, three frames 0x0001/0x0FFF/0x0800 → `cs` falls 141 cycles apart, each value captured in order; drop `cont` mid-frame 2 → frame 2 completes, no frame 3.
- `start` pulsed during SHIFT → ignored, no extra frame, no glitch on `cs`/`sclk`.
- Reset asserted at cycle 60 → `cs`=1, `sclk`=0 immediately; outputs 0; next `start` produces a clean full frame.
- CHANNELS=1, CLK_DIV=1, FRAME_BITS=16, DATA_BITS=16: 16'hFFFF → `data_out`=16'hFFFF, `frame_err`=0, done at cycle 34.

Source files
------------

// File: rtl/adc_rx_pkg.sv
// Shared definitions for the multi-lane SPI ADC receiver.
//   state_e       : receiver FSM states
//   frame_data()  : conversion-data slice (low data_bits of a frame, rest zero)
//   pad_nonzero() : 1 if any pad bit between data_bits and frame_bits is set
// Frames are handed over zero-extended to MAX_FRAME_BITS so the helpers can
// serve any FRAME_BITS/DATA_BITS combination up to that width.
package adc_rx_pkg;

  localparam int unsigned MAX_FRAME_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_QUIET
  } state_e;

  function automatic logic [MAX_FRAME_BITS-1:0] frame_data(
    input logic [MAX_FRAME_BITS-1:0] frame,
    input int unsigned               data_bits
  );
    logic [MAX_FRAME_BITS-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < MAX_FRAME_BITS; b++) begin
      if (b < data_bits) r[b] = frame[b];
    end
    return r;
  endfunction

  function automatic logic pad_nonzero(
    input logic [MAX_FRAME_BITS-1:0] frame,
    input int unsigned               frame_bits,
    input int unsigned               data_bits
  );
    logic r;
    r = 1'b0;
    for (int unsigned b = 0; b < MAX_FRAME_BITS; b++) begin
      if ((b >= data_bits) && (b < frame_bits) && frame[b]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_lane_shift.sv
// One sdata lane: MSB-first shift register plus a capture register that only
// changes at frame completion, so all lanes present their frames atomically.
//   clk_i      : system clock
//   rst_ni     : async active-low reset, clears partial shift and capture
//   shift_en_i : shift sdata_i in (asserted on the sclk 0->1 cycle)
//   sdata_i    : serial data from this lane's ADC
//   capture_i  : copy the shift register to frame_o
//   frame_o    : last completed frame
module adc_lane_shift #(
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  shift_en_i,
  input  logic                  sdata_i,
  input  logic                  capture_i,
  output logic [FRAME_BITS-1:0] frame_o
);

  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] frame_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      frame_q <= '0;
    end else begin
      if (shift_en_i) shift_q <= {shift_q[FRAME_BITS-2:0], sdata_i};
      if (capture_i)  frame_q <= shift_q;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/adc_spi_rx_multi.sv
// Multi-lane SPI ADC receiver. Drives a shared sclk/cs to CHANNELS serial
// ADCs, deserialises every sdata lane in parallel and presents the frames,
// their conversion data and a pad-bit error flag with a one-cycle done pulse.
//   clk, reset (async, active low)
//   start        : single-shot request, honoured only in IDLE
//   cont         : continuous mode, a new frame starts whenever IDLE is reached
//   sdata        : one serial input per lane
//   sclk, cs     : SPI clock (idles low) and active-low chip select
//   busy         : high from cs fall until back in IDLE
//   rx_done_tick : one-cycle pulse when a frame is complete
//   frame_reg    : raw frames, lane i at [i*FRAME_BITS +: FRAME_BITS]
//   data_out     : lane i = frame[DATA_BITS-1:0]
//   frame_err    : lane i set when any pad bit above the data field is 1
module adc_spi_rx_multi
  import adc_rx_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cont,
  input  logic [CHANNELS-1:0]            sdata,
  output logic                           sclk,
  output logic                           cs,
  output logic                           busy,
  output logic                           rx_done_tick,
  output logic [CHANNELS*FRAME_BITS-1:0] frame_reg,
  output logic [CHANNELS*DATA_BITS-1:0]  data_out,
  output logic [CHANNELS-1:0]            frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned QW    = $clog2(QUIET_CYCLES + 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic             shift_en;
  logic             capture;
  logic             div_last;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      qcnt_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      qcnt_q  <= qcnt_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    qcnt_d   = qcnt_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (start || cont) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        // First rising edge: the ADC has had the MSB out since cs fell.
        if (div_last) begin
          div_d    = '0;
          sclk_d   = 1'b1;
          shift_en = 1'b1;
          bit_d    = bit_q + 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == CNT_W'(FRAME_BITS)) begin
            // Last low half elapsed: close the frame.
            cs_d    = 1'b1;
            done_d  = 1'b1;
            capture = 1'b1;
            qcnt_d  = '0;
            state_d = ST_QUIET;
          end else begin
            sclk_d   = 1'b1;
            shift_en = 1'b1;
            bit_d    = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_QUIET: begin
        if (qcnt_q == QW'(QUIET_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cs           = cs_q;
  assign sclk         = sclk_q;
  assign busy         = (state_q != ST_IDLE);
  assign rx_done_tick = done_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [FRAME_BITS-1:0]     frame_w;
    logic [MAX_FRAME_BITS-1:0] frame_ext;

    adc_lane_shift #(
      .FRAME_BITS(FRAME_BITS)
    ) u_lane (
      .clk_i     (clk),
      .rst_ni    (reset),
      .shift_en_i(shift_en),
      .sdata_i   (sdata[i]),
      .capture_i (capture),
      .frame_o   (frame_w)
    );

    assign frame_ext = MAX_FRAME_BITS'(frame_w);
    assign frame_reg[i*FRAME_BITS +: FRAME_BITS] = frame_w;
    assign data_out[i*DATA_BITS +: DATA_BITS]    = DATA_BITS'(frame_data(frame_ext, DATA_BITS));
    assign frame_err[i] = pad_nonzero(frame_ext, FRAME_BITS, DATA_BITS);
  end

endmodule

// File: tb/tb_adc_spi_rx_multi.sv
// Bench for adc_spi_rx_multi: a default-parameter instance checked every
// cycle against a frame-timeline model, plus a CHANNELS=1/CLK_DIV=1 instance.
module tb_adc_spi_rx_multi;

  localparam int FB = 16;
  localparam int CD = 4;
  localparam int QC = 8;
  localparam int T  = 1 + CD * (2 * FB + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default instance
  logic        start_a = 1'b0, cont_a = 1'b0;
  logic [1:0]  sdata_a = '0;
  logic        sclk_a, cs_a, busy_a, rx_done_tick_a;
  logic [31:0] frame_reg_a;
  logic [23:0] data_out_a;
  logic [1:0]  frame_err_a;

  // single-lane, fast-clock instance
  logic        start_b = 1'b0, cont_b = 1'b0;
  logic [0:0]  sdata_b = '0;
  logic        sclk_b, cs_b, busy_b, rx_done_tick_b;
  logic [15:0] frame_reg_b;
  logic [15:0] data_out_b;
  logic [0:0]  frame_err_b;

  adc_spi_rx_multi dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cont(cont_a), .sdata(sdata_a),
    .sclk(sclk_a), .cs(cs_a), .busy(busy_a), .rx_done_tick(rx_done_tick_a),
    .frame_reg(frame_reg_a), .data_out(data_out_a), .frame_err(frame_err_a)
  );

  adc_spi_rx_multi #(
    .CHANNELS(1), .FRAME_BITS(16), .DATA_BITS(16), .CLK_DIV(1), .QUIET_CYCLES(8)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cont(cont_b), .sdata(sdata_b),
    .sclk(sclk_b), .cs(cs_b), .busy(busy_b), .rx_done_tick(rx_done_tick_b),
    .frame_reg(frame_reg_b), .data_out(data_out_b), .frame_err(frame_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Words each ADC will send in the frame that starts next.
  logic [15:0] nw0 = '0, nw1 = '0, nwb = '0;

  // ADC slave models: MSB out at cs fall, next bit after every sclk fall.
  initial begin : slave_a
    logic [15:0] w0, w1;
    int idx;
    logic cs_prev;
    w0 = '0; w1 = '0; idx = 0; cs_prev = 1'b1;
    forever begin
      @(cs_a or negedge sclk_a);
      if (cs_a !== cs_prev) begin
        cs_prev = cs_a;
        if (cs_a === 1'b0) begin w0 = nw0; w1 = nw1; idx = 15; end
      end else if (cs_a === 1'b0 && idx > 0) begin
        idx--;
      end
      sdata_a = {w1[idx], w0[idx]};
    end
  end

  initial begin : slave_b
    logic [15:0] w;
    int idx;
    logic cs_prev;
    w = '0; idx = 0; cs_prev = 1'b1;
    forever begin
      @(cs_b or negedge sclk_b);
      if (cs_b !== cs_prev) begin
        cs_prev = cs_b;
        if (cs_b === 1'b0) begin w = nwb; idx = 15; end
      end else if (cs_b === 1'b0 && idx > 0) begin
        idx--;
      end
      sdata_b = w[idx];
    end
  end

  // Event bookkeeping.
  int cyc = 0, done_cnt_a = 0, rises_a = 0, rises_b = 0;
  int falls_a[$];
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rx_done_tick_a === 1'b1) done_cnt_a++;
  end
  initial forever begin @(posedge sclk_a); rises_a++; end
  initial forever begin @(posedge sclk_b); rises_b++; end
  initial forever begin @(negedge cs_a); falls_a.push_back(cyc); end

  // Frame timeline model: m_n = 1 in the cycle after the sampling edge,
  // the frame occupies T + QC - 1 cycles before IDLE is seen again.
  int          m_n = 0;
  bit          m_active = 1'b0;
  logic [31:0] m_pend = '0, m_frame = '0;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 1'b0; m_n = 0; m_frame = '0;
    end else if (m_active) begin
      if (m_n == T + QC - 1) m_active = 1'b0;
      else begin
        m_n++;
        if (m_n == T) m_frame = m_pend;
      end
    end else if (start_a || cont_a) begin
      m_active = 1'b1; m_n = 1; m_pend = {nw1, nw0};
    end
  end

  initial begin : compare
    bit e_cs, e_sclk, e_busy, e_done;
    forever begin
      @(negedge clk);
      e_cs   = !(m_active && m_n <= T - 1);
      e_sclk = m_active && m_n >= CD + 1 && m_n < CD + 1 + 2 * CD * FB &&
               (((m_n - CD - 1) / CD) % 2 == 0);
      e_busy = m_active;
      e_done = m_active && m_n == T;
      chk("cs", 64'(cs_a), 64'(e_cs));
      chk("sclk", 64'(sclk_a), 64'(e_sclk));
      chk("busy", 64'(busy_a), 64'(e_busy));
      chk("rx_done_tick", 64'(rx_done_tick_a), 64'(e_done));
      chk("frame_reg", 64'(frame_reg_a), 64'(m_frame));
      chk("data_out", 64'(data_out_a), 64'({m_frame[27:16], m_frame[11:0]}));
      chk("frame_err", 64'(frame_err_a),
          64'({m_frame[31:28] != 4'h0, m_frame[15:12] != 4'h0}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    tick();
    for (int i = 0; i < 600 && (busy_a || busy_b); i++) tick();
    chk("idle_timeout", 64'(busy_a | busy_b), 64'(0));
  endtask

  // Called at posedge+2 with the DUT idle; returns the cycle index of done.
  task automatic shot_a(output int n_done);
    start_a = 1'b1;
    @(posedge clk);
    #2 start_a = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (rx_done_tick_a) begin n_done = c; break; end
    end
  endtask

  task automatic shot_b(output int n_done);
    start_b = 1'b1;
    @(posedge clk);
    #2 start_b = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (rx_done_tick_b) begin n_done = c; break; end
    end
  endtask

  task automatic wait_done_a();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rx_done_tick_a) begin got = 1'b1; break; end
    end
    chk("done_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_fall(input int k);
    for (int c = 0; c < 400 && falls_a.size() < k; c++) tick();
    chk("cs_fall_timeout", 64'(falls_a.size() >= k), 64'(1));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nd, r0, dc0, f0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs", 64'(cs_a), 64'(1));
    chk("rst_sclk", 64'(sclk_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_frame", 64'(frame_reg_a), 64'(0));
    reset = 1'b1;
    tick();

    // Single shot
    nw0 = 16'h0ABC; nw1 = 16'h0123; r0 = rises_a;
    shot_a(nd);
    chk("t1_done_cycle", 64'(nd), 64'(133));
    chk("t1_data", 64'(data_out_a), 64'(24'h123ABC));
    chk("t1_frame", 64'(frame_reg_a), 64'(32'h01230ABC));
    chk("t1_err", 64'(frame_err_a), 64'(0));
    chk("t1_rises", 64'(rises_a - r0), 64'(16));
    @(negedge clk);
    chk("t1_tick_one_cycle", 64'(rx_done_tick_a), 64'(0));

    // Pad error on lane 0
    wait_idle();
    nw0 = 16'h8ABC; nw1 = 16'h0123;
    shot_a(nd);
    chk("t2_err", 64'(frame_err_a), 64'(2'b01));
    chk("t2_data0", 64'(data_out_a[11:0]), 64'(12'hABC));
    chk("t2_frame0", 64'(frame_reg_a[15:0]), 64'(16'h8ABC));

    // Continuous: three frames, cont dropped during the third
    wait_idle();
    f0 = falls_a.size(); dc0 = done_cnt_a;
    nw0 = 16'h0001; nw1 = 16'($urandom); cont_a = 1'b1;
    wait_fall(f0 + 1);
    nw0 = 16'h0FFF; nw1 = 16'($urandom);
    wait_done_a();
    chk("t3_f0", 64'(data_out_a[11:0]), 64'(12'h001));
    wait_fall(f0 + 2);
    nw0 = 16'h0800; nw1 = 16'($urandom);
    wait_done_a();
    chk("t3_f1", 64'(data_out_a[11:0]), 64'(12'hFFF));
    wait_fall(f0 + 3);
    repeat (60) tick();
    cont_a = 1'b0;
    wait_done_a();
    chk("t3_f2", 64'(data_out_a[11:0]), 64'(12'h800));
    chk("t3_f2_err", 64'(frame_err_a[0]), 64'(0));
    wait_idle();
    repeat (300) tick();
    chk("t3_frames", 64'(done_cnt_a - dc0), 64'(3));
    chk("t3_period1", 64'(falls_a[f0 + 1] - falls_a[f0]), 64'(141));
    chk("t3_period2", 64'(falls_a[f0 + 2] - falls_a[f0 + 1]), 64'(141));

    // start pulsed during SHIFT is ignored
    dc0 = done_cnt_a; r0 = rises_a;
    nw0 = 16'h1234; nw1 = 16'h0567;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (50) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done_a();
    wait_idle();
    repeat (50) tick();
    chk("t4_frames", 64'(done_cnt_a - dc0), 64'(1));
    chk("t4_rises", 64'(rises_a - r0), 64'(16));

    // Reset in the middle of a frame
    nw0 = 16'hFFFF; nw1 = 16'hFFFF;
    start_a = 1'b1;
    @(posedge clk);
    #2 start_a = 1'b0;
    repeat (60) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t5_cs", 64'(cs_a), 64'(1));
    chk("t5_sclk", 64'(sclk_a), 64'(0));
    chk("t5_busy", 64'(busy_a), 64'(0));
    chk("t5_frame", 64'(frame_reg_a), 64'(0));
    chk("t5_data", 64'(data_out_a), 64'(0));
    chk("t5_err", 64'(frame_err_a), 64'(0));
    tick(); tick();
    reset = 1'b1;
    tick();
    nw0 = 16'h0F0F; nw1 = 16'h0C3A;
    shot_a(nd);
    chk("t5_done_cycle", 64'(nd), 64'(133));
    chk("t5_after_data", 64'(data_out_a), 64'(24'hC3AF0F));
    chk("t5_after_err", 64'(frame_err_a), 64'(0));

    // Single lane, CLK_DIV=1, no pad bits
    wait_idle();
    nwb = 16'hFFFF; r0 = rises_b;
    shot_b(nd);
    chk("b_done_cycle", 64'(nd), 64'(34));
    chk("b_data", 64'(data_out_b), 64'(16'hFFFF));
    chk("b_err", 64'(frame_err_b), 64'(0));
    chk("b_rises", 64'(rises_b - r0), 64'(16));
    wait_idle();
    nwb = 16'h8001;
    shot_b(nd);
    chk("b2_data", 64'(data_out_b), 64'(16'h8001));
    chk("b2_err", 64'(frame_err_b), 64'(0));
    chk("b2_cs", 64'(cs_b), 64'(1));

    // Random start/cont/word traffic, checked by the per-cycle compare
    wait_idle();
    for (int r = 0; r < 4000; r++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        nw0 = 16'($urandom);
        nw1 = 16'($urandom);
        if ($urandom_range(0, 1) == 1) nw0[15:12] = 4'h0;
        if ($urandom_range(0, 1) == 1) nw1[15:12] = 4'h0;
      end
      start_a = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) cont_a = ~cont_a;
    end
    start_a = 1'b0;
    cont_a  = 1'b0;
    wait_idle();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
